// File: rtl/intra_filter_pkg.sv
// intra_filter_pkg: shared parameter defaults for the intra filter accumulator
package intra_filter_pkg;
  localparam int DEF_NUM_TAPS = 4;
  localparam int DEF_IN_W = 16;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_SHIFT = 6;
  localparam int DEF_BLK_LEN = 32;
  localparam int SUM_W = DEF_IN_W + 3;
endpackage

// File: rtl/intra_clip.sv
// intra_clip: round, normalise and clip a signed tap sum to an unsigned sample
module intra_clip #(
  parameter int SUM_W = intra_filter_pkg::SUM_W,
  parameter int SHIFT = intra_filter_pkg::DEF_SHIFT,
  parameter int OUT_W = intra_filter_pkg::DEF_OUT_W
) (
  input  logic signed [SUM_W-1:0] sum_i,
  output logic        [OUT_W-1:0] sample_o
);
  // one guard bit keeps the rounding add from overflowing
  localparam logic signed [SUM_W:0] RND = (SUM_W+1)'(2 ** (SHIFT - 1));
  localparam logic signed [SUM_W:0] MAX = (SUM_W+1)'(2 ** OUT_W - 1);
  logic signed [SUM_W:0] rnd;
  logic signed [SUM_W:0] sh;
  always_comb begin
    rnd = (SUM_W+1)'(sum_i) + RND;
    sh = rnd >>> SHIFT;
    sample_o = sh[SUM_W] ? '0 : (sh > MAX) ? '1 : sh[OUT_W-1:0];
  end
endmodule

// File: rtl/intra_filter_acc.sv
// intra_filter_acc: two-stage tap-sum/clip pipeline with block-row position tracking
module intra_filter_acc
  import intra_filter_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int IN_W = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int BLK_LEN = DEF_BLK_LEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] p0,
  input  logic signed [IN_W-1:0] p1,
  input  logic signed [IN_W-1:0] p2,
  input  logic signed [IN_W-1:0] p3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sample,
  output logic                   out_last
);
  localparam int ACC_W = IN_W + $clog2(NUM_TAPS) + 1;
  localparam int CNT_W = $clog2(BLK_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_LEN - 1);
  logic                    en;
  logic                    v1_q;
  logic                    v2_q;
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;
  logic [OUT_W-1:0]        smp_d;
  logic [OUT_W-1:0]        smp_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [CNT_W-1:0]        cnt_q;
  assign en = !v2_q || out_ready;
  assign in_ready = en || !rst_n;
  assign sum_d = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2) + ACC_W'(p3);
  // the counter tracks output transfers only, independent of stage loads
  assign cnt_d = (v2_q && out_ready) ? ((cnt_q == LAST) ? '0 : cnt_q + 1'b1) : cnt_q;
  intra_clip #(
    .SUM_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_clip (
    .sum_i(sum_q),
    .sample_o(smp_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      sum_q <= '0;
      smp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (en) begin
        v1_q <= in_valid;
        sum_q <= sum_d;
        v2_q <= v1_q;
        smp_q <= smp_d;
      end
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = v2_q;
  assign out_sample = smp_q;
  assign out_last = v2_q && (cnt_q == LAST);
endmodule

// File: tb/tb_intra_filter_acc.sv
// tb_intra_filter_acc: directed and random stimulus against a scoreboard of model samples
module tb_intra_filter_acc;
  import intra_filter_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [15:0] p0, p1, p2, p3;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_sample;
  logic out_last;
  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int ocnt = 0;
  logic [7:0] sb[$];

  intra_filter_acc dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .p0(p0),
    .p1(p1),
    .p2(p2),
    .p3(p3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sample(out_sample),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(logic signed [15:0] a, b, c, d);
    int s;
    s = int'(a) + int'(b) + int'(c) + int'(d);
    s = (s + (1 << (DEF_SHIFT - 1))) >>> DEF_SHIFT;
    if (s < 0) return 8'd0;
    if (s > (1 << DEF_OUT_W) - 1) return 8'd255;
    return 8'(s);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic signed [15:0] a, b, c, d, logic r);
    in_valid = v;
    p0 = a;
    p1 = b;
    p2 = c;
    p3 = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(logic v, logic r);
    drive(v, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), r);
  endtask

  // monitor: transfers happen at the next rising edge
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        ocnt = 0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("sample", 32'(out_sample), 32'(e));
            chk("last", 32'(out_last), 32'((ocnt % DEF_BLK_LEN) == DEF_BLK_LEN - 1));
          end
          ocnt++;
        end else if (!out_valid) chk("idle_last", 32'(out_last), 0);
        if (in_valid && in_ready) begin
          sb.push_back(model(p0, p1, p2, p3));
          pushed++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_sample", 32'(out_sample), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    // single sample latency
    drive(1, -300, 3700, 3000, -300, 1);
    chk("lat_early", 32'(out_valid), 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_sample", 32'(out_sample), 95);
    drive(0, 0, 0, 0, 0, 1);
    // clipping and rounding boundaries
    drive(1, -500, 0, 0, 0, 1);
    drive(1, 20000, 0, 0, 0, 1);
    drive(1, 32767, 32767, 32767, 32767, 1);
    drive(1, -32768, -32768, -32768, -32768, 1);
    drive(1, 16319, 0, 0, 0, 1);
    drive(1, 16352, 0, 0, 0, 1);
    drive(1, -32, 0, 0, 0, 1);
    drive(1, -33, 0, 0, 0, 1);
    drive(1, 31, 0, 0, 0, 1);
    drive(1, 32, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    chk("boundary_drained", 32'(sb.size()), 0);
    // fresh row of 33 samples: last on 32nd, wrap on 33rd
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    repeat (33) drive_rand(1, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    chk("row_count", 32'(ocnt), 33);
    // stall with the pipeline full
    repeat (3) drive_rand(1, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      p0 = 16'($urandom);
      out_ready = 1'b0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_hold", 32'(out_sample), 32'(sb[0]));
      @(posedge clk);
      #1;
    end
    repeat (4) drive_rand(1, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 1);
    chk("stall_drained", 32'(sb.size()), 0);
    // random handshakes
    n0 = pushed;
    for (int c = 0; c < 20000 && pushed - n0 < 1000; c++)
      drive_rand($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    chk("rand_count", 32'(pushed - n0 >= 1000), 1);
    for (int c = 0; c < 20 && sb.size() > 0; c++) drive(0, 0, 0, 0, 0, 1);
    chk("rand_drained", 32'(sb.size()), 0);
    // reset mid-row
    repeat (10) drive_rand(1, 1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_last", 32'(out_last), 0);
    rst_n = 1'b1;
    repeat (32) drive_rand(1, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    chk("post_rst_row", 32'(ocnt), 32);
    chk("final_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/intra_filter_acc.md
INTRA_FILTER_ACC -- requirements
Module: intra_filter_acc

Interface
REQ-001 Parameter NUM_TAPS, default 4, is the number of product terms summed per sample.
REQ-002 Parameter IN_W, default 16, is the width of each signed product term.
REQ-003 Parameter OUT_W, default 8, is the width of the unsigned output sample.
REQ-004 Parameter SHIFT, default 6, is the normalisation right-shift; rounding offset is 2^(SHIFT-1).
REQ-005 Parameter BLK_LEN, default 32, is the number of output samples per block row.
REQ-006 Port clk  input  1  is the sole clock; all state updates on its rising edge.
REQ-007 Port rst_n  input  1  is the reset, synchronous, active-low.
REQ-008 Port in_valid  input  1  means the current product set is valid.
REQ-009 Port in_ready  output  1  means the block accepts a product set this cycle.
REQ-010 Port p0..p3  input  IN_W each, signed  are the tap products from the upstream MCM stage.
REQ-011 Port out_valid  output  1  means out_sample is valid.
REQ-012 Port out_ready  input  1  means downstream accepts out_sample this cycle.
REQ-013 Port out_sample  output  OUT_W, unsigned  is the filtered, rounded and clipped sample.
REQ-014 Port out_last  output  1  marks the final sample of a BLK_LEN row.

Function
REQ-015 Pipeline SHALL have two register stages: S1 holds the tap sum, S2 holds the clipped sample.
REQ-016 Pipeline advance enable en SHALL equal (!out_valid || out_ready); in_ready SHALL equal en.
REQ-017 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-018 S1 SHALL register sign-extended p0+p1+p2+p3 at IN_W+3 = 19 bits, so no overflow occurs for any input.
REQ-019 S1 valid SHALL load in_valid whenever en=1 and SHALL hold when en=0.
REQ-020 S2 SHALL compute (sum + 2^(SHIFT-1)) arithmetic-shifted right by SHIFT, then clip to [0, 2^OUT_W-1].
REQ-021 S2 SHALL load result and out_valid from S1 when en=1, and SHALL hold when en=0.
REQ-022 With out_ready held high, latency SHALL be 2 cycles from input transfer to out_valid, at throughput 1 sample per cycle.
REQ-023 out_sample SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Pipeline bubbles (in_valid=0) SHALL propagate as out_valid=0 and SHALL NOT advance the counter.
REQ-025 Position counter cnt, range 0..BLK_LEN-1, SHALL increment on each output transfer and wrap to 0 after BLK_LEN-1.
REQ-026 out_last SHALL equal out_valid && (cnt == BLK_LEN-1).
REQ-027 A simultaneous output transfer and S2 load SHALL count the transferred sample only.

Reset
REQ-028 When rst_n=0 at a clock edge, S1/S2 valid, cnt, out_sample and out_last SHALL clear to 0.
REQ-029 in_ready SHALL be 1 during reset.
REQ-030 Reset asserted mid-row SHALL discard in-flight samples and restart cnt at 0.

Structure
REQ-031 Package intra_filter_pkg SHALL hold the parameter defaults and a derived constant SUM_W = IN_W+3.
REQ-032 Clipping SHALL be one sub-module, intra_clip, which is combinational and parameterised by SUM_W, SHIFT and OUT_W.

Verification
REQ-033 Products {-300, 3700, 3000, -300}, out_ready=1 -> out_sample=95 exactly 2 cycles later.
REQ-034 Products summing to -500 -> 0; products summing to 20000 -> 255; all four at 32767 -> 255; all four at -32768 -> 0.
REQ-035 Streaming 32 valid sets with out_ready=1 -> out_last=1 on the 32nd output only; the 33rd output shows out_last=0 (wrap).
REQ-036 out_ready=0 for 5 cycles with the pipeline full -> in_ready=0, out_sample held; on release, samples emerge in order with none lost or duplicated.
REQ-037 Random in_valid/out_ready over 1000 samples -> scoreboard order and values match the reference model; out_last every 32 transfers.
REQ-038 rst_n=0 asserted after 10 samples of a row -> out_valid=0 the next cycle; the first post-reset row asserts out_last on its 32nd sample.
